// File: rtl/dec_stage_pipe.sv
// RV32I-subset decode stage: bypassed register file read, control decode, immediate
// generation, and the ID/EX register. Load-use hazards stall the upstream stage and insert a bubble.
module dec_stage_pipe #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int CNTW = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [31:0]              instr,
  output logic                     in_ready,
  input  logic                     flush,
  input  logic                     regwrite_WB,
  input  logic [$clog2(NREG)-1:0]  wa_WB,
  input  logic [XLEN-1:0]          wdata_WB,
  output logic                     out_valid,
  output logic [XLEN-1:0]          rda,
  output logic [XLEN-1:0]          rdb,
  output logic [XLEN-1:0]          imm,
  output logic                     ALUsrc,
  output logic [1:0]               ALUOP,
  output logic                     regwrite,
  output logic                     memtoreg,
  output logic                     memread,
  output logic                     memwrite,
  output logic                     branch,
  output logic [$clog2(NREG)-1:0]  wa,
  output logic [$clog2(NREG)-1:0]  ra1,
  output logic [$clog2(NREG)-1:0]  ra2,
  output logic [2:0]               funct3,
  output logic                     funct7,
  output logic [CNTW-1:0]          stall_cnt
);

  localparam int AW = $clog2(NREG);

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_BR  = 2'b01;
  localparam logic [1:0] ALU_R   = 2'b10;
  localparam logic [1:0] ALU_I   = 2'b11;

  function automatic logic signed [XLEN-1:0] sext12(input logic [11:0] v);
    return {{(XLEN-12){v[11]}}, v};
  endfunction

  function automatic logic signed [XLEN-1:0] sext13(input logic [12:0] v);
    return {{(XLEN-13){v[12]}}, v};
  endfunction

  logic [XLEN-1:0] regs [NREG];

  logic [6:0]             opcode;
  logic [AW-1:0]          rs1_p0, rs2_p0, rd_p0;
  logic [XLEN-1:0]        rda_p0, rdb_p0;
  logic signed [XLEN-1:0] imm_p0;
  logic                   alusrc_p0, regwrite_p0, memtoreg_p0, memread_p0, memwrite_p0, branch_p0;
  logic [1:0]             aluop_p0;
  logic                   use_rs1_p0, use_rs2_p0;
  logic                   stall;

  logic                   vld_p1;
  logic [XLEN-1:0]        rda_p1, rdb_p1;
  logic signed [XLEN-1:0] imm_p1;
  logic                   alusrc_p1, regwrite_p1, memtoreg_p1, memread_p1, memwrite_p1, branch_p1;
  logic [1:0]             aluop_p1;
  logic [AW-1:0]          wa_p1, ra1_p1, ra2_p1;
  logic [2:0]             funct3_p1;
  logic                   funct7_p1;
  logic [CNTW-1:0]        stall_cnt_p1;

  assign opcode = instr[6:0];
  assign rd_p0  = instr[7 +: AW];
  assign rs1_p0 = instr[15 +: AW];
  assign rs2_p0 = instr[20 +: AW];

  // x0 is never written, so it reads as zero without a special case on the read side.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (regwrite_WB && wa_WB != '0) begin
      regs[wa_WB] <= wdata_WB;
    end
  end

  always_comb begin
    rda_p0 = (regwrite_WB && wa_WB != '0 && wa_WB == rs1_p0) ? wdata_WB : regs[rs1_p0];
    rdb_p0 = (regwrite_WB && wa_WB != '0 && wa_WB == rs2_p0) ? wdata_WB : regs[rs2_p0];
  end

  always_comb begin
    alusrc_p0   = 1'b0;
    aluop_p0    = ALU_ADD;
    regwrite_p0 = 1'b0;
    memtoreg_p0 = 1'b0;
    memread_p0  = 1'b0;
    memwrite_p0 = 1'b0;
    branch_p0   = 1'b0;
    imm_p0      = '0;
    use_rs1_p0  = 1'b0;
    use_rs2_p0  = 1'b0;
    case (opcode)
      OP_R: begin
        aluop_p0    = ALU_R;
        regwrite_p0 = 1'b1;
        use_rs1_p0  = 1'b1;
        use_rs2_p0  = 1'b1;
      end
      OP_I: begin
        alusrc_p0   = 1'b1;
        aluop_p0    = ALU_I;
        regwrite_p0 = 1'b1;
        imm_p0      = sext12(instr[31:20]);
        use_rs1_p0  = 1'b1;
      end
      OP_LD: begin
        alusrc_p0   = 1'b1;
        regwrite_p0 = 1'b1;
        memtoreg_p0 = 1'b1;
        memread_p0  = 1'b1;
        imm_p0      = sext12(instr[31:20]);
        use_rs1_p0  = 1'b1;
      end
      OP_ST: begin
        alusrc_p0   = 1'b1;
        memwrite_p0 = 1'b1;
        imm_p0      = sext12({instr[31:25], instr[11:7]});
        use_rs1_p0  = 1'b1;
        use_rs2_p0  = 1'b1;
      end
      OP_BR: begin
        aluop_p0    = ALU_BR;
        branch_p0   = 1'b1;
        imm_p0      = sext13({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0});
        use_rs1_p0  = 1'b1;
        use_rs2_p0  = 1'b1;
      end
      default: ;
    endcase
  end

  // Only operands the instruction actually reads can create a load-use hazard.
  assign stall = in_valid && vld_p1 && memread_p1 && (wa_p1 != '0) &&
                 ((use_rs1_p0 && wa_p1 == rs1_p0) || (use_rs2_p0 && wa_p1 == rs2_p0));
  assign in_ready = flush || !stall;

  // ---- ID/EX boundary ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1       <= 1'b0;
      rda_p1       <= '0;
      rdb_p1       <= '0;
      imm_p1       <= '0;
      alusrc_p1    <= 1'b0;
      aluop_p1     <= 2'b00;
      regwrite_p1  <= 1'b0;
      memtoreg_p1  <= 1'b0;
      memread_p1   <= 1'b0;
      memwrite_p1  <= 1'b0;
      branch_p1    <= 1'b0;
      wa_p1        <= '0;
      ra1_p1       <= '0;
      ra2_p1       <= '0;
      funct3_p1    <= '0;
      funct7_p1    <= 1'b0;
      stall_cnt_p1 <= '0;
    end else if (!flush && in_valid && !stall) begin
      vld_p1      <= 1'b1;
      rda_p1      <= rda_p0;
      rdb_p1      <= rdb_p0;
      imm_p1      <= imm_p0;
      alusrc_p1   <= alusrc_p0;
      aluop_p1    <= aluop_p0;
      regwrite_p1 <= regwrite_p0;
      memtoreg_p1 <= memtoreg_p0;
      memread_p1  <= memread_p0;
      memwrite_p1 <= memwrite_p0;
      branch_p1   <= branch_p0;
      wa_p1       <= rd_p0;
      ra1_p1      <= rs1_p0;
      ra2_p1      <= rs2_p0;
      funct3_p1   <= instr[14:12];
      funct7_p1   <= instr[30];
    end else begin
      // Flush, stall bubble or idle: controls cleared, data fields left stale.
      vld_p1      <= 1'b0;
      alusrc_p1   <= 1'b0;
      aluop_p1    <= 2'b00;
      regwrite_p1 <= 1'b0;
      memtoreg_p1 <= 1'b0;
      memread_p1  <= 1'b0;
      memwrite_p1 <= 1'b0;
      branch_p1   <= 1'b0;
      if (!flush && stall && stall_cnt_p1 != '1) stall_cnt_p1 <= stall_cnt_p1 + CNTW'(1);
    end
  end

  assign out_valid = vld_p1;
  assign rda       = rda_p1;
  assign rdb       = rdb_p1;
  assign imm       = imm_p1;
  assign ALUsrc    = alusrc_p1;
  assign ALUOP     = aluop_p1;
  assign regwrite  = regwrite_p1;
  assign memtoreg  = memtoreg_p1;
  assign memread   = memread_p1;
  assign memwrite  = memwrite_p1;
  assign branch    = branch_p1;
  assign wa        = wa_p1;
  assign ra1       = ra1_p1;
  assign ra2       = ra2_p1;
  assign funct3    = funct3_p1;
  assign funct7    = funct7_p1;
  assign stall_cnt = stall_cnt_p1;

endmodule

// File: tb/tb_dec_stage_pipe.sv
// Scoreboard bench for dec_stage_pipe: directed instructions push hand-computed ID/EX
// contents; a negedge monitor pops and compares whenever out_valid is high.
module tb_dec_stage_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, flush, regwrite_WB;
  logic [31:0] instr, wdata_WB;
  logic [4:0]  wa_WB;
  logic        in_ready, out_valid;
  logic [31:0] rda, rdb, imm;
  logic        ALUsrc, regwrite, memtoreg, memread, memwrite, branch;
  logic [1:0]  ALUOP;
  logic [4:0]  wa, ra1, ra2;
  logic [2:0]  funct3;
  logic        funct7;
  logic [15:0] stall_cnt;

  dec_stage_pipe #(.XLEN(32), .NREG(32), .CNTW(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr), .in_ready(in_ready),
    .flush(flush), .regwrite_WB(regwrite_WB), .wa_WB(wa_WB), .wdata_WB(wdata_WB),
    .out_valid(out_valid), .rda(rda), .rdb(rdb), .imm(imm), .ALUsrc(ALUsrc), .ALUOP(ALUOP),
    .regwrite(regwrite), .memtoreg(memtoreg), .memread(memread), .memwrite(memwrite),
    .branch(branch), .wa(wa), .ra1(ra1), .ra2(ra2), .funct3(funct3), .funct7(funct7),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rda, rdb, imm;
    logic [1:0]  aluop;
    logic [5:0]  ctl;  // {ALUsrc, regwrite, memtoreg, memread, memwrite, branch}
    logic [4:0]  wa, ra1, ra2;
    logic [2:0]  f3;
    logic        f7;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                              input logic [1:0] op, input logic [5:0] ctl, input logic [4:0] w,
                              input logic [4:0] r1, input logic [4:0] r2, input logic [2:0] f3,
                              input logic f7);
    exp_t e;
    e.rda = a; e.rdb = b; e.imm = im; e.aluop = op; e.ctl = ctl;
    e.wa = w; e.ra1 = r1; e.ra2 = r2; e.f3 = f3; e.f7 = f7; e.cyc = 0;
    return e;
  endfunction

  // Monitor: every valid ID/EX entry must match the oldest expectation, one cycle after issue.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", 32'(out_valid), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("latency", cyc, e.cyc + 1);
          chk("rda", rda, e.rda);
          chk("rdb", rdb, e.rdb);
          chk("imm", imm, e.imm);
          chk("ALUOP", 32'(ALUOP), 32'(e.aluop));
          chk("ctl", 32'({ALUsrc, regwrite, memtoreg, memread, memwrite, branch}), 32'(e.ctl));
          chk("wa", 32'(wa), 32'(e.wa));
          chk("ra1", 32'(ra1), 32'(e.ra1));
          chk("ra2", 32'(ra2), 32'(e.ra2));
          chk("funct3", 32'(funct3), 32'(e.f3));
          chk("funct7", 32'(funct7), 32'(e.f7));
        end
      end else begin
        chk("bubble_ctl", 32'({ALUsrc, ALUOP, regwrite, memtoreg, memread, memwrite, branch}), 32'd0);
      end
    end
  end

  task automatic step(input logic v, input logic [31:0] ins, input logic fl,
                      input logic we, input logic [4:0] a, input logic [31:0] d,
                      input logic exp_rdy, input logic push, input exp_t e);
    exp_t q;
    in_valid = v; instr = ins; flush = fl;
    regwrite_WB = we; wa_WB = a; wdata_WB = d;
    if (push) begin
      q = e;
      q.cyc = cyc;
      sb.push_back(q);
    end
    @(negedge clk);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] ADDI_6_5_1 = {12'd1, 5'd5, 3'd0, 5'd6, 7'h13};
  localparam logic [31:0] ADD_8_7_0  = {7'd0, 5'd0, 5'd7, 3'd0, 5'd8, 7'h33};
  localparam logic [31:0] ADD_9_0_7  = {7'd0, 5'd7, 5'd0, 3'd0, 5'd9, 7'h33};
  localparam logic [31:0] LW_3_1     = {12'd0, 5'd1, 3'd2, 5'd3, 7'h03};
  localparam logic [31:0] ADD_4_3_2  = {7'd0, 5'd2, 5'd3, 3'd0, 5'd4, 7'h33};
  localparam logic [31:0] ADDI_4_0_3 = {12'd3, 5'd0, 3'd0, 5'd4, 7'h13};
  localparam logic [31:0] LW_0_1     = {12'd0, 5'd1, 3'd2, 5'd0, 7'h03};
  localparam logic [31:0] ADD_5_0_0  = {7'd0, 5'd0, 5'd0, 3'd0, 5'd5, 7'h33};
  localparam logic [31:0] BEQ_M8     = {7'h7F, 5'd2, 5'd1, 3'd0, 5'b11001, 7'h63};
  localparam logic [31:0] SW_M4      = {7'h7F, 5'd2, 5'd1, 3'd2, 5'b11100, 7'h23};
  localparam logic [31:0] BAD_OP     = 32'hFFF0_007F;
  localparam logic [31:0] ADD_4_1_2  = {7'd0, 5'd2, 5'd1, 3'd0, 5'd4, 7'h33};

  exp_t nul;
  exp_t e_lw3;

  initial begin
    nul = mk(0, 0, 0, 2'b00, 6'd0, 0, 0, 0, 0, 1'b0);
    e_lw3 = mk(32'h100, 32'h0, 32'h0, 2'b00, 6'b111100, 5'd3, 5'd1, 5'd0, 3'd2, 1'b0);
    rst = 1'b1; in_valid = 1'b0; instr = '0; flush = 1'b0;
    regwrite_WB = 1'b0; wa_WB = '0; wdata_WB = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_ctl", 32'({ALUsrc, ALUOP, regwrite, memtoreg, memread, memwrite, branch}), 32'd0);
    chk("rst_rda", rda, 32'd0);
    rst = 1'b0;

    // WB then addi using it
    step(0, 0, 0, 1, 5'd5, 32'h1234, 1, 0, nul);
    step(1, ADDI_6_5_1, 0, 0, 0, 0, 1, 1,
         mk(32'h1234, 32'h0, 32'h1, 2'b11, 6'b110000, 5'd6, 5'd5, 5'd1, 3'd0, 1'b0));
    // same-cycle bypass, then x0 write ignored
    step(1, ADD_8_7_0, 0, 1, 5'd7, 32'hAA, 1, 1,
         mk(32'hAA, 32'h0, 32'h0, 2'b10, 6'b010000, 5'd8, 5'd7, 5'd0, 3'd0, 1'b0));
    step(1, ADD_9_0_7, 0, 1, 5'd0, 32'hFFFF, 1, 1,
         mk(32'h0, 32'hAA, 32'h0, 2'b10, 6'b010000, 5'd9, 5'd0, 5'd7, 3'd0, 1'b0));
    step(0, 0, 0, 1, 5'd1, 32'h100, 1, 0, nul);
    step(0, 0, 0, 1, 5'd2, 32'h22, 1, 0, nul);

    // load-use: one stall cycle, bubble, then the held add issues
    step(1, LW_3_1, 0, 0, 0, 0, 1, 1, e_lw3);
    step(1, ADD_4_3_2, 0, 0, 0, 0, 0, 0, nul);
    chk("bubble_out_valid", 32'(out_valid), 32'd0);
    chk("stall_cnt_1", 32'(stall_cnt), 32'd1);
    step(1, ADD_4_3_2, 0, 0, 0, 0, 1, 1,
         mk(32'h0, 32'h22, 32'h0, 2'b10, 6'b010000, 5'd4, 5'd3, 5'd2, 3'd0, 1'b0));

    // unused rs2 field and x0 destination: no stall
    step(1, LW_3_1, 0, 0, 0, 0, 1, 1, e_lw3);
    step(1, ADDI_4_0_3, 0, 0, 0, 0, 1, 1,
         mk(32'h0, 32'h0, 32'h3, 2'b11, 6'b110000, 5'd4, 5'd0, 5'd3, 3'd0, 1'b0));
    step(1, LW_0_1, 0, 0, 0, 0, 1, 1,
         mk(32'h100, 32'h0, 32'h0, 2'b00, 6'b111100, 5'd0, 5'd1, 5'd0, 3'd2, 1'b0));
    step(1, ADD_5_0_0, 0, 0, 0, 0, 1, 1,
         mk(32'h0, 32'h0, 32'h0, 2'b10, 6'b010000, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0));
    chk("stall_cnt_still_1", 32'(stall_cnt), 32'd1);

    // negative B/S immediates, unknown opcode
    step(1, BEQ_M8, 0, 0, 0, 0, 1, 1,
         mk(32'h100, 32'h22, 32'hFFFFFFF8, 2'b01, 6'b000001, 5'd25, 5'd1, 5'd2, 3'd0, 1'b1));
    step(1, SW_M4, 0, 0, 0, 0, 1, 1,
         mk(32'h100, 32'h22, 32'hFFFFFFFC, 2'b00, 6'b100010, 5'd28, 5'd1, 5'd2, 3'd2, 1'b1));
    step(1, BAD_OP, 0, 0, 0, 0, 1, 1,
         mk(32'h0, 32'h0, 32'h0, 2'b00, 6'b000000, 5'd0, 5'd0, 5'd31, 3'd0, 1'b1));

    // flush while a load-use hazard is pending
    step(1, LW_3_1, 0, 0, 0, 0, 1, 1, e_lw3);
    step(1, ADD_4_3_2, 1, 0, 0, 0, 1, 0, nul);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_stall_cnt", 32'(stall_cnt), 32'd1);

    // second stall, then reset in the middle of a third
    step(1, LW_3_1, 0, 0, 0, 0, 1, 1, e_lw3);
    step(1, ADD_4_3_2, 0, 0, 0, 0, 0, 0, nul);
    step(1, ADD_4_3_2, 0, 0, 0, 0, 1, 1,
         mk(32'h0, 32'h22, 32'h0, 2'b10, 6'b010000, 5'd4, 5'd3, 5'd2, 3'd0, 1'b0));
    chk("stall_cnt_2", 32'(stall_cnt), 32'd2);
    step(1, LW_3_1, 0, 0, 0, 0, 1, 1, e_lw3);
    in_valid = 1'b1; instr = ADD_4_3_2;
    @(negedge clk);
    chk("pre_rst_in_ready", 32'(in_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_ctl", 32'({ALUsrc, ALUOP, regwrite, memtoreg, memread, memwrite, branch}), 32'd0);
    chk("arst_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_rda", rda, 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst = 1'b0;
    step(1, ADD_4_1_2, 0, 0, 0, 0, 1, 1,
         mk(32'h0, 32'h0, 32'h0, 2'b10, 6'b010000, 5'd4, 5'd1, 5'd2, 3'd0, 1'b0));
    repeat (3) step(0, 0, 0, 0, 0, 0, 1, 0, nul);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
